operation_executor: RTL and testbench
=====================================

OPERATION_EXECUTOR -- requirements
Module: operation_executor

Interface
REQ-001 The block SHALL have parameter OPW, default `IR_BFW_OP_SING` (4), meaning formatted operation word width.
REQ-002 The block SHALL have parameter AW, default 8, meaning memory address width.
REQ-003 The block SHALL have parameter DW, default 8, meaning memory data width.
REQ-004 The block SHALL have parameter RD_LAT, default 1 (legal 1..7), meaning memory read latency in cycles.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have port clk  in  1  system clock, all logic on its rising edge.
REQ-007 The block SHALL have port rst  in  1  synchronous active-high reset.
REQ-008 The block SHALL have port op_in  in  OPW  formatted operation: [3:2] opcode (00 NOP, 01 W, 10 R, 11 RW), [1] polarity, [0] end-of-element.
REQ-009 The block SHALL have port op_valid  in  1  op_in/addr_in valid.
REQ-010 The block SHALL have port op_ready  out  1  executor can accept an op.
REQ-011 The block SHALL have port addr_in  in  AW  target address of the op.
REQ-012 The block SHALL have port bg_in  in  DW  background data pattern, sampled at accept.
REQ-013 The block SHALL have ports mem_addr (out, AW), mem_we (out, 1), mem_re (out, 1), mem_wdata (out, DW), and mem_rdata (in, DW), forming the memory-under-test port.
REQ-014 The block SHALL have ports fail (out, 1, sticky miscompare), fail_addr (out, AW, address of first miscompare), fail_data (out, DW, read data of first miscompare) and fail_cnt (out, 8, saturating miscompare count).
REQ-015 The block SHALL have ports elem_done (out, 1, one-cycle pulse when an op with end-of-element set completes) and busy (out, 1, high when state is not IDLE).

Function
REQ-016 The block SHALL accept an op only on a cycle with op_valid=1 and op_ready=1; op_ready SHALL equal 1 exactly when state=IDLE.
REQ-017 The block SHALL register op, addr_in and bg_in at accept; expected data SHALL be bg XOR {DW{polarity}}.
REQ-018 The block SHALL implement FSM states IDLE, WRITE, READ, WAIT, CMP and WBACK.
REQ-019 On accept of a NOP, the FSM SHALL stay in IDLE, drive no memory strobe and pulse elem_done next cycle if end-of-element is set.
REQ-020 On accept of a W, the FSM SHALL go to WRITE for one cycle with mem_we=1, mem_addr=captured addr and mem_wdata=expected, then return to IDLE.
REQ-021 On accept of an R or RW, the FSM SHALL go to READ for one cycle with mem_re=1, then WAIT for RD_LAT-1 cycles (skipped when RD_LAT=1), then CMP, sampling mem_rdata in CMP.
REQ-022 The op latency from the accept edge to the return to IDLE SHALL be 1 cycle for W, RD_LAT+1 cycles for R and RD_LAT+2 cycles for RW.
REQ-023 In CMP, a miscompare (mem_rdata != expected) SHALL set fail, increment fail_cnt saturating at 255, and load fail_addr/fail_data only if fail was 0 beforehand.
REQ-024 For RW, CMP SHALL be followed by WBACK for one cycle with mem_we=1 and mem_wdata=~expected at the same address, then IDLE.
REQ-025 mem_we and mem_re SHALL never both be 1; mem_addr and mem_wdata SHALL hold their last values when no strobe is active.
REQ-026 elem_done SHALL pulse on the cycle the FSM returns to IDLE from an op with end-of-element=1, and never otherwise.
REQ-027 A miscompare SHALL NOT stall or abort execution; subsequent ops proceed normally.
REQ-028 The WAIT counter SHALL be 3 bits, load RD_LAT-1 on entry to READ and never wrap.

Reset
REQ-029 While rst=1 the block SHALL force state IDLE, and on the next cycle op_ready=1, busy=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, fail=0, fail_addr=0, fail_data=0, fail_cnt=0 and elem_done=0.
REQ-030 Reset asserted mid-op SHALL abandon the op with no further strobes and no elem_done pulse.

Structure
REQ-031 The opcode encodings, field bit positions and FSM state encodings SHALL live in the shared defines.v package, with OPW default `IR_BFW_OP_SING`.
REQ-032 The block SHALL be a single module with no sub-modules; the comparator SHALL be inline.

Verification
REQ-033 The bench SHALL check that op 0100 (W, pol 0) at addr 0x05 with bg 0xA5 produces one cycle with mem_we=1, mem_addr=0x05 and mem_wdata=0xA5, and that op_ready returns after 1 cycle.
REQ-034 The bench SHALL check that with RD_LAT=2, op 1010 (R, pol 1) at 0x10 with bg 0xA5 and memory returning 0x5A gives fail=0, no elem_done, and an op_ready low time of 3 cycles.
REQ-035 The bench SHALL check that op 1101 (RW, end) at 0x20 with bg 0x00 and memory returning 0x01 gives fail=1, fail_addr=0x20, fail_data=0x01 and fail_cnt=1, then a write of 0xFF, then an elem_done pulse.
REQ-036 The bench SHALL check that after a second miscompare at 0x30, fail_addr stays 0x20 and fail_cnt=2; and that 300 miscompares saturate fail_cnt at 255.
REQ-037 The bench SHALL check that asserting rst during WAIT produces no mem_we/elem_done and all outputs reset, and that op_valid held high in IDLE with no pending op is accepted the next cycle.
REQ-038 The bench SHALL check that op 0001 (NOP, end) gives no strobes and an elem_done pulse.

Source files
------------

// File: rtl/operation_executor_pkg.sv
`default_nettype none
//============================================================================
// Module      : operation_executor_pkg
// Description : Shared definitions for the memory-test operation executor.
//               Holds the operation word layout, opcode encodings and FSM
//               state encodings, so producers of operation words and the
//               executor agree on a single definition.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Contents    : IR_BFW_OP_SING  - default formatted operation word width
//               c_OP_*          - bit positions of the operation word fields
//               opcode_e        - NOP / W / R / RW opcodes
//               state_e         - executor FSM states
//============================================================================

// Width of a single formatted operation word. Guarded so that a
// project-wide definition takes precedence.
`ifndef IR_BFW_OP_SING
`define IR_BFW_OP_SING 4
`endif

package operation_executor_pkg;

    // Operation word layout: [3:2] opcode, [1] polarity, [0] end-of-element
    localparam int c_OP_EOE_BIT  = 0;
    localparam int c_OP_POL_BIT  = 1;
    localparam int c_OP_CODE_LSB = 2;
    localparam int c_OP_CODE_W   = 2;

    // Width of the saturating miscompare counter
    localparam int c_FAIL_CNT_W  = 8;

    // Width of the read-latency wait counter (covers RD_LAT up to 7)
    localparam int c_WAIT_CNT_W  = 3;

    typedef enum logic [1:0] {
        OPC_NOP = 2'b00,
        OPC_W   = 2'b01,
        OPC_R   = 2'b10,
        OPC_RW  = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CMP   = 3'd4,
        ST_WBACK = 3'd5
    } state_e;

endpackage : operation_executor_pkg

`default_nettype wire

// File: rtl/operation_executor.sv
`default_nettype none
//============================================================================
// Module      : operation_executor
// Description : Executes one formatted memory-test operation at a time
//               against a memory under test. W writes the expected pattern,
//               R reads and compares, RW reads, compares and writes back the
//               inverted pattern. Miscompares are logged (sticky flag, first
//               failing address/data, saturating count) without stalling.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Parameters  : OPW    - formatted operation word width
//               AW     - memory address width
//               DW     - memory data width
//               RD_LAT - memory read latency in cycles (1..7)
// Ports       : clk, rst              - clock, synchronous active-high reset
//               op_in/op_valid/op_ready - operation handshake
//               addr_in, bg_in        - target address, background pattern
//               mem_*                 - memory-under-test port
//               fail, fail_addr, fail_data, fail_cnt - miscompare log
//               elem_done             - pulse when an end-of-element op ends
//               busy                  - executor not idle
//============================================================================

module operation_executor
    import operation_executor_pkg::*;
#(
    parameter int OPW    = `IR_BFW_OP_SING,
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [OPW-1:0]          op_in,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [AW-1:0]           addr_in,
    input  logic [DW-1:0]           bg_in,

    output logic [AW-1:0]           mem_addr,
    output logic                    mem_we,
    output logic                    mem_re,
    output logic [DW-1:0]           mem_wdata,
    input  logic [DW-1:0]           mem_rdata,

    output logic                    fail,
    output logic [AW-1:0]           fail_addr,
    output logic [DW-1:0]           fail_data,
    output logic [c_FAIL_CNT_W-1:0] fail_cnt,

    output logic                    elem_done,
    output logic                    busy
);

    // Number of WAIT cycles between READ and CMP
    localparam logic [c_WAIT_CNT_W-1:0] c_WAIT_LOAD = c_WAIT_CNT_W'(RD_LAT - 1);
    localparam logic [c_FAIL_CNT_W-1:0] c_FAIL_MAX  = '1;

    //------------------------------------------------------------------------
    // Registered state
    //------------------------------------------------------------------------
    state_e                    state_q;
    opcode_e                   opc_q;
    logic                      eoe_q;
    logic [DW-1:0]             exp_q;
    logic [c_WAIT_CNT_W-1:0]   wait_cnt_q;

    logic [AW-1:0]             mem_addr_q;
    logic                      mem_we_q;
    logic                      mem_re_q;
    logic [DW-1:0]             mem_wdata_q;

    logic                      fail_q;
    logic [AW-1:0]             fail_addr_q;
    logic [DW-1:0]             fail_data_q;
    logic [c_FAIL_CNT_W-1:0]   fail_cnt_q;
    logic                      elem_done_q;

    //------------------------------------------------------------------------
    // Combinational helpers
    //------------------------------------------------------------------------
    opcode_e                   opc_d;
    logic                      eoe_d;
    logic [DW-1:0]             exp_d;
    logic                      miscmp_d;
    logic [c_FAIL_CNT_W-1:0]   fail_cnt_d;

    // Decode of the incoming operation word; only used on an accept
    assign opc_d = opcode_e'(op_in[c_OP_CODE_LSB +: c_OP_CODE_W]);
    assign eoe_d = op_in[c_OP_EOE_BIT];

    // Polarity 1 inverts the background pattern
    assign exp_d = bg_in ^ {DW{op_in[c_OP_POL_BIT]}};

    // Inline comparator; only meaningful while in CMP
    assign miscmp_d = (mem_rdata != exp_q);

    // Miscompare counter sticks at its maximum instead of wrapping
    assign fail_cnt_d = (fail_cnt_q == c_FAIL_MAX) ? c_FAIL_MAX
                                                   : fail_cnt_q + 1'b1;

    //------------------------------------------------------------------------
    // Executor FSM with registered outputs
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            opc_q       <= OPC_NOP;
            eoe_q       <= 1'b0;
            exp_q       <= '0;
            wait_cnt_q  <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_wdata_q <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_cnt_q  <= '0;
            elem_done_q <= 1'b0;
        end else begin
            // Strobes and the done pulse are single-cycle by default;
            // address and write data hold unless a new strobe loads them.
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            elem_done_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (op_valid) begin
                        opc_q <= opc_d;
                        eoe_q <= eoe_d;
                        exp_q <= exp_d;
                        case (opc_d)
                            OPC_NOP: begin
                                // Nothing to do on the memory; still signal
                                // the element boundary if requested.
                                elem_done_q <= eoe_d;
                            end
                            OPC_W: begin
                                state_q     <= ST_WRITE;
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= addr_in;
                                mem_wdata_q <= exp_d;
                            end
                            default: begin
                                // R and RW both start with a read
                                state_q    <= ST_READ;
                                mem_re_q   <= 1'b1;
                                mem_addr_q <= addr_in;
                                wait_cnt_q <= c_WAIT_LOAD;
                            end
                        endcase
                    end
                end

                ST_WRITE: begin
                    state_q     <= ST_IDLE;
                    elem_done_q <= eoe_q;
                end

                ST_READ: begin
                    // With a single-cycle memory the data is already due
                    // in the next cycle, so WAIT is skipped.
                    if (wait_cnt_q == '0) begin
                        state_q <= ST_CMP;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    // Counts down to zero and stops there
                    if (wait_cnt_q > c_WAIT_CNT_W'(1)) begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end else begin
                        wait_cnt_q <= '0;
                        state_q    <= ST_CMP;
                    end
                end

                ST_CMP: begin
                    if (miscmp_d) begin
                        fail_q     <= 1'b1;
                        fail_cnt_q <= fail_cnt_d;
                        // Only the first miscompare is captured
                        if (!fail_q) begin
                            fail_addr_q <= mem_addr_q;
                            fail_data_q <= mem_rdata;
                        end
                    end
                    if (opc_q == OPC_RW) begin
                        // Write back the inverted pattern at the same address
                        state_q     <= ST_WBACK;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= ~exp_q;
                    end else begin
                        state_q     <= ST_IDLE;
                        elem_done_q <= eoe_q;
                    end
                end

                ST_WBACK: begin
                    state_q     <= ST_IDLE;
                    elem_done_q <= eoe_q;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    //------------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------------
    assign op_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_wdata = mem_wdata_q;
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign fail_cnt  = fail_cnt_q;
    assign elem_done = elem_done_q;

endmodule : operation_executor

`default_nettype wire

// File: tb/tb_operation_executor.sv
`default_nettype none
//============================================================================
// Module      : tb_operation_executor
// Description : Self-checking bench for operation_executor. A transaction
//               level model predicts every output on every cycle from the
//               op that is in flight and the cycle offset since its accept;
//               directed ops add hand-computed literal expectations.
// Revision    : 1.0 - initial release
//============================================================================

module tb_operation_executor;

    localparam int OPW    = 4;
    localparam int AW     = 8;
    localparam int DW     = 8;
    localparam int RD_LAT = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [OPW-1:0]  op_in;
    logic            op_valid;
    logic            op_ready;
    logic [AW-1:0]   addr_in;
    logic [DW-1:0]   bg_in;
    logic [AW-1:0]   mem_addr;
    logic            mem_we;
    logic            mem_re;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            fail;
    logic [AW-1:0]   fail_addr;
    logic [DW-1:0]   fail_data;
    logic [7:0]      fail_cnt;
    logic            elem_done;
    logic            busy;

    always #5 clk = ~clk;

    operation_executor #(
        .OPW    (OPW),
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .op_in     (op_in),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .addr_in   (addr_in),
        .bg_in     (bg_in),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .fail_cnt  (fail_cnt),
        .elem_done (elem_done),
        .busy      (busy)
    );

    //------------------------------------------------------------------------
    // Check bookkeeping
    //------------------------------------------------------------------------
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    //------------------------------------------------------------------------
    // Memory under test: RD_LAT-deep read pipeline, preloaded on reset
    //------------------------------------------------------------------------
    logic [DW-1:0] mem     [256];
    logic [DW-1:0] rd_pipe [RD_LAT];

    assign mem_rdata = rd_pipe[RD_LAT-1];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h33;
            mem[8'h10] <= 8'h5A;
            mem[8'h20] <= 8'h01;
            mem[8'h30] <= 8'h77;
            for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            rd_pipe[0] <= mem[mem_addr];
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    //------------------------------------------------------------------------
    // Behavioural model: op in flight + offset k of the current cycle
    // after its accept edge. Busy cycles: W 1, R RD_LAT+1, RW RD_LAT+2.
    //------------------------------------------------------------------------
    bit          m_seen_rst = 1'b0;
    bit          m_active, m_eoe, m_mis, m_done, m_fail;
    int          m_k, m_cnt;
    logic [1:0]  m_opc;
    logic [7:0]  m_exp, m_addr, m_rd, m_faddr, m_fdata, m_last_addr, m_last_wdata;

    function automatic int op_len(input logic [1:0] opc);
        case (opc)
            2'b01:   return 1;
            2'b10:   return RD_LAT + 1;
            2'b11:   return RD_LAT + 2;
            default: return 0;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_seen_rst = 1'b1;
                m_active = 0; m_k = 0; m_done = 0; m_mis = 0; m_eoe = 0;
                m_fail = 0; m_faddr = 0; m_fdata = 0; m_cnt = 0;
                m_last_addr = 0; m_last_wdata = 0; m_opc = 0; m_exp = 0;
                m_addr = 0; m_rd = 0;
            end else begin
                m_done = 0;
                if (m_active) begin
                    m_k++;
                    if (m_opc == 2'b11 && m_k == RD_LAT + 2) m_last_wdata = ~m_exp;
                    if (m_opc[1] && m_k == RD_LAT + 2 && m_mis) begin
                        if (!m_fail) begin
                            m_faddr = m_addr;
                            m_fdata = m_rd;
                        end
                        m_fail = 1;
                        if (m_cnt < 255) m_cnt++;
                    end
                    if (m_k == op_len(m_opc) + 1) begin
                        m_active = 0;
                        m_done   = m_eoe;
                    end
                end else if (op_valid) begin
                    m_opc  = op_in[3:2];
                    m_eoe  = op_in[0];
                    m_exp  = bg_in ^ {DW{op_in[1]}};
                    m_addr = addr_in;
                    m_k    = 1;
                    if (m_opc == 2'b00) begin
                        m_done = m_eoe;
                    end else begin
                        m_active    = 1;
                        m_last_addr = addr_in;
                        if (m_opc == 2'b01) m_last_wdata = m_exp;
                        m_rd  = mem[addr_in];
                        m_mis = (m_rd != m_exp);
                    end
                end
            end
        end
    end

    //------------------------------------------------------------------------
    // Per-cycle compare against the model, plus event counters
    //------------------------------------------------------------------------
    int          cyc = 0;
    int          n_we = 0, n_re = 0, n_done = 0;
    int          last_we_cyc = 0, last_done_cyc = 0;
    logic [7:0]  last_we_addr = 0, last_we_data = 0;

    initial begin
        bit exp_we, exp_re;
        forever begin
            @(negedge clk);
            cyc++;
            if (m_seen_rst) begin
                exp_we = m_active && ((m_opc == 2'b01 && m_k == 1) ||
                                      (m_opc == 2'b11 && m_k == RD_LAT + 2));
                exp_re = m_active && m_opc[1] && m_k == 1;
                chk("op_ready",  32'(op_ready),  32'(!m_active));
                chk("busy",      32'(busy),      32'(m_active));
                chk("mem_we",    32'(mem_we),    32'(exp_we));
                chk("mem_re",    32'(mem_re),    32'(exp_re));
                chk("mem_addr",  32'(mem_addr),  32'(m_last_addr));
                chk("mem_wdata", 32'(mem_wdata), 32'(m_last_wdata));
                chk("elem_done", 32'(elem_done), 32'(m_done));
                chk("fail",      32'(fail),      32'(m_fail));
                chk("fail_addr", 32'(fail_addr), 32'(m_faddr));
                chk("fail_data", 32'(fail_data), 32'(m_fdata));
                chk("fail_cnt",  32'(fail_cnt),  32'(m_cnt));
                if (mem_we) begin
                    n_we++;
                    last_we_cyc  = cyc;
                    last_we_addr = mem_addr;
                    last_we_data = mem_wdata;
                end
                if (mem_re) n_re++;
                if (elem_done) begin
                    n_done++;
                    last_done_cyc = cyc;
                end
            end
        end
    end

    //------------------------------------------------------------------------
    // Stimulus helpers
    //------------------------------------------------------------------------
    // Presents an op, waits for its accept, then counts the cycles op_ready
    // stays low afterwards. Ends on the negedge where op_ready is back.
    task automatic send_op(input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] bg, output int lowcyc);
        int guard;
        @(negedge clk);
        op_in = op; addr_in = a; bg_in = bg; op_valid = 1'b1;
        guard = 0;
        while (!op_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_timeout", 32'(guard < 50), 32'd1);
        @(negedge clk);
        op_valid = 1'b0;
        lowcyc = 0;
        while (!op_ready && lowcyc < 50) begin
            lowcyc++;
            @(negedge clk);
        end
        chk("ready_timeout", 32'(lowcyc < 50), 32'd1);
    endtask

    // Lets the compare process record the current cycle before counters are read
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    //------------------------------------------------------------------------
    // Directed sequence
    //------------------------------------------------------------------------
    initial begin
        int low, we0, re0, done0;

        rst = 1'b1; op_valid = 1'b0; op_in = '0; addr_in = '0; bg_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_op_ready",  32'(op_ready),  32'd1);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_mem_we",    32'(mem_we),    32'd0);
        chk("rst_fail_cnt",  32'(fail_cnt),  32'd0);

        // W, pol 0 at 0x05 with bg 0xA5
        we0 = n_we;
        send_op(4'b0100, 8'h05, 8'hA5, low);
        settle();
        chk("w_low_cycles", 32'(low),          32'd1);
        chk("w_we_count",   32'(n_we - we0),   32'd1);
        chk("w_addr",       32'(last_we_addr), 32'h05);
        chk("w_data",       32'(last_we_data), 32'hA5);

        // R, pol 1 at 0x10 with bg 0xA5; memory holds 0x5A
        re0 = n_re; done0 = n_done;
        send_op(4'b1010, 8'h10, 8'hA5, low);
        settle();
        chk("r_low_cycles", 32'(low),            32'd3);
        chk("r_re_count",   32'(n_re - re0),     32'd1);
        chk("r_fail",       32'(fail),           32'd0);
        chk("r_no_done",    32'(n_done - done0), 32'd0);

        // RW, pol 0, end at 0x20 with bg 0x00; memory holds 0x01
        we0 = n_we; done0 = n_done;
        send_op(4'b1101, 8'h20, 8'h00, low);
        settle();
        chk("rw_low_cycles", 32'(low),            32'(RD_LAT + 2));
        chk("rw_fail",       32'(fail),           32'd1);
        chk("rw_fail_addr",  32'(fail_addr),      32'h20);
        chk("rw_fail_data",  32'(fail_data),      32'h01);
        chk("rw_fail_cnt",   32'(fail_cnt),       32'd1);
        chk("rw_we_count",   32'(n_we - we0),     32'd1);
        chk("rw_wb_addr",    32'(last_we_addr),   32'h20);
        chk("rw_wb_data",    32'(last_we_data),   32'hFF);
        chk("rw_done_count", 32'(n_done - done0), 32'd1);
        chk("rw_done_after_wb", 32'(last_done_cyc - last_we_cyc), 32'd1);

        // Second miscompare at 0x30 (memory 0x77, expected 0x00)
        send_op(4'b1000, 8'h30, 8'h00, low);
        settle();
        chk("mis2_fail_addr", 32'(fail_addr), 32'h20);
        chk("mis2_fail_data", 32'(fail_data), 32'h01);
        chk("mis2_fail_cnt",  32'(fail_cnt),  32'd2);

        // NOP with end-of-element
        we0 = n_we; re0 = n_re; done0 = n_done;
        send_op(4'b0001, 8'h44, 8'h00, low);
        settle();
        chk("nop_low_cycles", 32'(low),            32'd0);
        chk("nop_no_we",      32'(n_we - we0),     32'd0);
        chk("nop_no_re",      32'(n_re - re0),     32'd0);
        chk("nop_done",       32'(n_done - done0), 32'd1);

        // 300 further miscompares at 0x40 (memory 0x33, expected 0x00)
        for (int i = 0; i < 300; i++) send_op(4'b1000, 8'h40, 8'h00, low);
        settle();
        chk("sat_fail_cnt",  32'(fail_cnt),  32'd255);
        chk("sat_fail_addr", 32'(fail_addr), 32'h20);

        // Reset during WAIT of an RW-with-end op; a W is held valid
        // through reset and must be taken on the first idle cycle.
        we0 = n_we; done0 = n_done;
        @(negedge clk);
        op_in = 4'b1101; addr_in = 8'h50; bg_in = 8'h00; op_valid = 1'b1;
        @(negedge clk);                     // READ
        op_in = 4'b0100; addr_in = 8'h07; bg_in = 8'h3C;
        @(negedge clk);                     // WAIT
        chk("abort_in_wait", 32'(busy && !mem_re && !mem_we), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_op_ready",  32'(op_ready),  32'd1);
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_mem_we",    32'(mem_we),    32'd0);
        chk("abort_mem_re",    32'(mem_re),    32'd0);
        chk("abort_mem_addr",  32'(mem_addr),  32'd0);
        chk("abort_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("abort_fail",      32'(fail),      32'd0);
        chk("abort_fail_addr", 32'(fail_addr), 32'd0);
        chk("abort_fail_data", 32'(fail_data), 32'd0);
        chk("abort_fail_cnt",  32'(fail_cnt),  32'd0);
        chk("abort_elem_done", 32'(elem_done), 32'd0);
        @(negedge clk);                     // held W accepted at the edge before
        op_valid = 1'b0;
        chk("held_w_we",    32'(mem_we),    32'd1);
        chk("held_w_addr",  32'(mem_addr),  32'h07);
        chk("held_w_wdata", 32'(mem_wdata), 32'h3C);
        repeat (3) @(negedge clk);
        settle();
        chk("abort_we_count",  32'(n_we - we0),     32'd1);
        chk("abort_no_done",   32'(n_done - done0), 32'd0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end

endmodule : tb_operation_executor

`default_nettype wire
